// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, response
// error codes, RISC-V funct3 encodings and memory size encodings, plus a
// helper that flags funct3 values the unit cannot execute.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // 011 and 11x are undefined for loads; stores have no unsigned forms.
  function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
  endfunction

endpackage

// File: rtl/load_store_unit_access_check.sv
// Combinational request checker for the load/store unit.
// Ports:
//   store   in  1   1 = store, 0 = load
//   funct3  in  3   RISC-V funct3 of the request
//   addr    in  32  byte address
//   err     out 2   error code (ERR_* from the package), ERR_OK when clean
//   fault   out 1   request must be rejected without touching memory
module load_store_unit_access_check
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH    = 50,
  parameter bit RO_WORD0 = 1'b1
) (
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [1:0]  err,
  output logic        fault
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  // Checks are applied in priority order; the first one that trips wins.
  always_comb begin
    err   = ERR_OK;
    fault = 1'b0;
    if (funct3_illegal(store, funct3)) begin
      err   = ERR_ILLEGAL;
      fault = 1'b1;
    end else if ((funct3[1:0] == SIZE_H && addr[0]) ||
                 (funct3[1:0] == SIZE_W && addr[1:0] != 2'b00)) begin
      err   = ERR_MISALIGN;
      fault = 1'b1;
    end else if (addr >= ADDR_LIMIT) begin
      err   = ERR_RANGE;
      fault = 1'b1;
    end else if (RO_WORD0 && store && addr < 32'd4) begin
      // Word 0 is refreshed from an external input every cycle, so a store
      // there would be silently lost; reject it instead.
      err   = ERR_ILLEGAL;
      fault = 1'b1;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load/store request at a time from the core,
// checks it, drives the data memory's control strobes for exactly one cycle,
// waits out the memory's one-cycle synchronous read and returns a single
// response pulse.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                core request handshake
//   req_store/req_funct3/req_addr/req_wdata   request fields
//   resp_valid/resp_err/resp_rdata     one-cycle response pulse and payload
//   mem_write/mem_read                 memory strobes (ACCESS state only)
//   store_size/load_size/load_unsigned memory size controls (latched funct3)
//   endereco/write_data                memory byte address and store data
//   read_data                          memory read data, valid after mem_read
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH      = 50,
  parameter int ADDR_WIDTH = 10,
  parameter bit RO_WORD0   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  store_size,
  output logic [1:0]  load_size,
  output logic        load_unsigned,
  output logic [31:0] endereco,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  lsu_state_t state, next_state;

  logic                  lat_store;
  logic [2:0]            lat_funct3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;

  logic [1:0] chk_err;
  logic       chk_fault;
  logic       accept;

  load_store_unit_access_check #(
    .DEPTH    (DEPTH),
    .RO_WORD0 (RO_WORD0)
  ) u_check (
    .store  (req_store),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .err    (chk_err),
    .fault  (chk_fault)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Strobes come straight from the state register so they never glitch and
  // mem_write/mem_read can never be high together.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = chk_fault ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_write  = lat_store;
        mem_read   = !lat_store;
        next_state = lat_store ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: next_state = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured on accept even for faulting requests; the
  // strobes stay low for those, so the memory never acts on them. The reset
  // funct3 of W gives the required idle size outputs of 10 / signed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_store  <= 1'b0;
      lat_funct3 <= F3_W;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_err   <= ERR_OK;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        lat_store  <= req_store;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr[ADDR_WIDTH-1:0];
        lat_wdata  <= req_wdata;
        resp_err   <= chk_err;
        resp_rdata <= '0;
      end else if (state == ST_WAIT) begin
        resp_rdata <= read_data;
      end
    end
  end

  assign store_size    = lat_funct3[1:0];
  assign load_size     = lat_funct3[1:0];
  assign load_unsigned = lat_funct3[2];
  assign endereco      = {{(32-ADDR_WIDTH){1'b0}}, lat_addr};
  assign write_data    = lat_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit paired with a behavioural data
// memory. Expected responses come from a byte-level reference model that
// applies the request rules directly.
module tb_load_store_unit;

  localparam int DEPTH      = 50;
  localparam int ADDR_WIDTH = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write, mem_read;
  logic [1:0]  store_size, load_size;
  logic        load_unsigned;
  logic [31:0] endereco, write_data;
  logic [31:0] read_data = '0;

  logic [31:0] n_in = 32'h0BAD_F00D;

  int check_count = 0;
  int pass_count  = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

  logic [31:0] last_rdata;
  logic [1:0]  last_err;

  always #5 clk = ~clk;

  load_store_unit #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .RO_WORD0(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .store_size(store_size), .load_size(load_size),
    .load_unsigned(load_unsigned),
    .endereco(endereco), .write_data(write_data),
    .read_data(read_data)
  );

  // Behavioural data memory: word array, synchronous read with extension,
  // word 0 refreshed from n_in every cycle.
  logic [31:0] mem_words [0:DEPTH-1];
  logic [31:0] m_word, m_rd, m_mask, m_data;
  logic [4:0]  m_bsh, m_hsh;
  int          m_idx;

  initial for (int i = 0; i < DEPTH; i++) mem_words[i] = '0;

  always @(posedge clk) begin
    m_idx  = int'(endereco[ADDR_WIDTH-1:2]);
    m_bsh  = {endereco[1:0], 3'b000};
    m_hsh  = {endereco[1], 4'b0000};
    m_rd   = '0;
    m_word = (m_idx < DEPTH) ? mem_words[m_idx] : '0;
    if (mem_read) begin
      case (load_size)
        2'b00: begin
          m_rd = (m_word >> m_bsh) & 32'hFF;
          if (!load_unsigned && m_rd[7]) m_rd = m_rd | 32'hFFFF_FF00;
        end
        2'b01: begin
          m_rd = (m_word >> m_hsh) & 32'hFFFF;
          if (!load_unsigned && m_rd[15]) m_rd = m_rd | 32'hFFFF_0000;
        end
        default: m_rd = m_word;
      endcase
    end
    read_data <= m_rd;
    if (mem_write && m_idx < DEPTH) begin
      case (store_size)
        2'b00: begin m_mask = 32'hFF << m_bsh; m_data = (write_data & 32'hFF) << m_bsh; end
        2'b01: begin m_mask = 32'hFFFF << m_hsh; m_data = (write_data & 32'hFFFF) << m_hsh; end
        default: begin m_mask = 32'hFFFF_FFFF; m_data = write_data; end
      endcase
      mem_words[m_idx] <= (m_word & ~m_mask) | m_data;
    end
    mem_words[0] <= n_in;
  end

  // Strobe activity monitor.
  always @(negedge clk) begin
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  // Reference model: plain byte array of the memory contents.
  logic [7:0] ref_mem [0:DEPTH*4-1];
  initial for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;

  function automatic int ref_nbytes(input logic [2:0] f3);
    int s = int'(f3) % 4;
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] ref_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 >= 6 || (st && f3 >= 4)) return 2'd3;
    if (a % ref_nbytes(f3) != 0) return 2'd1;
    if (a >= DEPTH*4) return 2'd2;
    if (st && a < 4) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [7:0] ref_byte(input int a);
    if (a < 4) return 8'((n_in >> (8*a)) & 32'hFF);
    return ref_mem[a];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = ref_nbytes(f3);
    for (int k = 0; k < n; k++) v = v | (32'(ref_byte(int'(a) + k)) << (8*k));
    if (f3 < 4 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One complete request: drive, wait for the response, check it against
  // the reference model, then update the model for successful stores.
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    int          e_lat, lat;
    logic        got;
    e_err   = ref_err(st, f3, a);
    e_rdata = (e_err == 0 && !st) ? ref_load(f3, a) : 32'd0;
    e_lat   = (e_err != 0) ? 1 : (st ? 2 : 3);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
    end
    checkOutput({tag, "_ready"}, {31'd0, got}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; lat = i; break; end
    end
    checkOutput({tag, "_resp_seen"}, {31'd0, got}, 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(e_lat));
    checkOutput({tag, "_err"}, {30'd0, resp_err}, {30'd0, e_err});
    checkOutput({tag, "_rdata"}, resp_rdata, e_rdata);
    last_rdata = resp_rdata;
    last_err   = resp_err;
    @(negedge clk);
    checkOutput({tag, "_pulse_one"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, "_rd_cnt"}, 32'(rd_cnt), (e_err == 0 && !st) ? 32'd1 : 32'd0);
    checkOutput({tag, "_wr_cnt"}, 32'(wr_cnt), (e_err == 0 && st) ? 32'd1 : 32'd0);
    if (e_err == 0 && st)
      for (int k = 0; k < ref_nbytes(f3); k++) ref_mem[int'(a) + k] = 8'((wd >> (8*k)) & 32'hFF);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, "_resp_err"}, {30'd0, resp_err}, 32'd0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_strobes"}, {30'd0, mem_write, mem_read}, 32'd0);
    checkOutput({tag, "_sizes"}, {27'd0, store_size, load_size, load_unsigned}, 32'b10100);
    checkOutput({tag, "_endereco"}, endereco, 32'd0);
    checkOutput({tag, "_write_data"}, write_data, 32'd0);
  endtask

  logic [31:0] resp_q [$];
  int          acc_cyc;
  int          resp_seen;
  logic        st_r;
  logic [2:0]  f3_r;
  logic [31:0] a_r;
  int          sel;

  initial begin
    #12;
    checkReset("reset");
    @(negedge clk); rst_n = 1'b1;

    // Directed memory sequence.
    applyStimulus("sw_28", 1'b1, 3'b010, 32'h28, 32'hDEAD_BEEF);
    checkOutput("tap_word10", mem_words[10], 32'hDEAD_BEEF);
    applyStimulus("lw_28", 1'b0, 3'b010, 32'h28, 32'h0);
    checkOutput("lw_28_value", last_rdata, 32'hDEAD_BEEF);
    applyStimulus("sb_2d", 1'b1, 3'b000, 32'h2D, 32'hAAAA_5580);
    applyStimulus("lb_2d", 1'b0, 3'b000, 32'h2D, 32'h0);
    checkOutput("lb_2d_value", last_rdata, 32'hFFFF_FF80);
    applyStimulus("lbu_2d", 1'b0, 3'b100, 32'h2D, 32'h0);
    checkOutput("lbu_2d_value", last_rdata, 32'h0000_0080);
    applyStimulus("lhu_2c", 1'b0, 3'b101, 32'h2C, 32'h0);
    checkOutput("lhu_2c_value", last_rdata, 32'h0000_8000);
    applyStimulus("lw_0", 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("lw_0_value", last_rdata, n_in);

    // Faults.
    applyStimulus("lh_31", 1'b0, 3'b001, 32'h31, 32'h0);
    checkOutput("lh_31_code", {30'd0, last_err}, 32'd1);
    applyStimulus("sw_2a", 1'b1, 3'b010, 32'h2A, 32'h1234_5678);
    checkOutput("sw_2a_code", {30'd0, last_err}, 32'd1);
    applyStimulus("lw_c8", 1'b0, 3'b010, 32'hC8, 32'h0);
    checkOutput("lw_c8_code", {30'd0, last_err}, 32'd2);
    applyStimulus("lw_c4", 1'b0, 3'b010, 32'hC4, 32'h0);
    applyStimulus("f3_011", 1'b0, 3'b011, 32'h28, 32'h0);
    checkOutput("f3_011_code", {30'd0, last_err}, 32'd3);
    applyStimulus("sw_0", 1'b1, 3'b010, 32'h0, 32'h5555_AAAA);
    checkOutput("sw_0_code", {30'd0, last_err}, 32'd3);
    applyStimulus("sbu", 1'b1, 3'b100, 32'h40, 32'h0);
    checkOutput("sbu_code", {30'd0, last_err}, 32'd3);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h28;
    @(posedge clk); #1;
    req_addr = 32'h2C;
    acc_cyc = 0; resp_seen = 0; resp_q.delete();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin resp_seen++; resp_q.push_back(resp_rdata); end
      if (req_ready && acc_cyc == 0) begin
        acc_cyc = c;
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_accept_cycle", 32'(acc_cyc), 32'd4);
    checkOutput("b2b_resp_count", 32'(resp_seen), 32'd2);
    checkOutput("b2b_first", (resp_q.size() > 0) ? resp_q[0] : 32'hX, ref_load(3'b010, 32'h28));
    checkOutput("b2b_second", (resp_q.size() > 1) ? resp_q[1] : 32'hX, ref_load(3'b010, 32'h2C));

    // Reset during the ACCESS cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_write", {31'd0, mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1 checkReset("midreset");
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    checkOutput("rst_no_resp", 32'(resp_seen), 32'd0);
    checkOutput("rst_mem_untouched", mem_words[12], 32'd0);
    applyStimulus("post_rst_lw", 1'b0, 3'b010, 32'h30, 32'h0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      st_r = 1'($urandom_range(0, 1));
      f3_r = 3'($urandom_range(0, 7));
      sel  = int'($urandom_range(0, 9));
      a_r  = 32'($urandom_range(0, 199));
      if (sel == 0) a_r = 32'($urandom_range(190, 260));
      else if (sel < 6) a_r = a_r & ~32'd3;
      applyStimulus("rand", st_r, f3_r, a_r, $urandom);
    end

    checkOutput("strobes_exclusive", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
